int_sync_async_crossing_source: RTL
===================================

// Module: int_sync_async_crossing_source
// PURPOSE
//   Source-clock-domain end of the interrupt async crossing. Registers N interrupt lines so the
//   crossing wire is driven only by flops (glitch-free), and optionally stretches pulse-type
//   interrupts so the far-side 3-stage synchronizer in a slower or unrelated clock cannot miss them.
//   Sits at the interrupt producer (device/PLIC side); auto_out_sync feeds the async sink directly.
// PARAMETERS
//   NUM_INT    1     number of interrupt lines
//   EDGE_MASK  '0    NUM_INT-bit; bit i=1: line i is pulse/edge type (stretched), 0: level type
//   HOLD       8     cycles an edge-type output stays high per rising edge; legal 1..255
// PORTS
//   clock          in   1        source-domain clock
//   reset          in   1        asynchronous, active-low (0 = reset asserted)
//   auto_in        in   NUM_INT  raw interrupt lines, clock-domain, may glitch between edges
//   auto_out_sync  out  NUM_INT  crossing wires to async sink; each bit driven straight from a flop
// BEHAVIOUR
//   Reset: all flops (r, prev, cnt, out) clear to 0 asynchronously; auto_out_sync = 0 while reset=0
//     and after release until a qualifying input. Reset mid-pulse aborts the stretch immediately.
//   Common: r[i] <= auto_in[i] each cycle (stage 1). auto_out_sync[i] is the Q of an out flop;
//     no gate between that flop and the port (hard requirement, checked in review/lint).
//   Level bit (EDGE_MASK[i]=0): out[i] <= r[i]. Latency 2 cycles input->output; follows every
//     level change, including single-cycle pulses (not stretched).
//   Edge bit (EDGE_MASK[i]=1): prev[i] <= r[i]; rise[i] = r[i] & ~prev[i].
//     IDLE  (cnt=0, out=0): rise -> cnt<=HOLD-1, out<=1 -> ACTIVE.
//     ACTIVE(out=1): rise -> reload cnt<=HOLD-1 (retrigger, stays ACTIVE);
//       else cnt!=0 -> cnt<=cnt-1; else cnt=0 -> out<=0 -> IDLE.
//     Result: out high exactly HOLD cycles after the last rise; latency 2 cycles input->output.
//     Input held high continuously: one HOLD-cycle pulse only; needs fall then rise to re-fire.
//     Rise on the same cycle ACTIVE would expire: reload wins, no low gap.
//     Input already high at reset release: prev=0, so one rise seen -> one pulse.
//   cnt width = clog2(HOLD) (min 1); decrement never wraps (guarded by cnt!=0).
//   HOLD=1: edge bit gives one-cycle pulse per rise (stretch disabled but edge-qualified).
//   Guidance: HOLD >= 3*(f_src/f_sink)+3 so the sink's 3-flop synchronizer samples each pulse.
//   Bits are independent; no cross-bit ordering guaranteed across the crossing.
// STRUCTURE
//   Package int_xing_pkg: INT_XING_SINK_DEPTH=3, function cnt_w(hold), min-HOLD helper
//     hold_min(ratio), localparam checks (HOLD in 1..255, NUM_INT>=1).
//   Sub-module int_pulse_stretcher (one bit: clock, reset, d, q; params HOLD): prev/cnt/out
//     FSM above. Top: r register vector + generate loop picking level flop or stretcher per
//     EDGE_MASK bit. Elaboration error on illegal parameters.
// TESTING
//   1 Reset: hold reset=0 with auto_in='1, release -> auto_out_sync=0 for 2 cycles; level bits
//     go 1 at cycle 2; edge bits pulse HOLD=8 cycles then 0 while input stays 1.
//   2 Level: NUM_INT=4, EDGE_MASK=0, drive 1-cycle pulse on bit 2 at cycle 10 -> out bit 2
//     high exactly cycle 12, other bits 0 throughout.
//   3 Edge stretch: EDGE_MASK=1, HOLD=8, 1-cycle pulse at cycle 10 -> out high cycles 12..19,
//     low at 20; second pulse at cycle 15 -> out held high through cycle 24 (retrigger).
//   4 Boundary: HOLD=8, pulses at cycles 10 and 18 (rise seen on expiring cycle) -> out high
//     continuously 12..27, no low gap; HOLD=1 single pulse -> 1-cycle output at cycle 12.
//   5 Reset mid-pulse: assert reset at cycle 14 during stretch -> out 0 asynchronously same
//     cycle; after release with input 0 -> out stays 0; next rise fires a full HOLD pulse.
//   6 End-to-end: connect to async sink at f_sink=f_src/3, HOLD from hold_min(3); random
//     1-cycle pulses spaced >HOLD apart -> sink sees every pulse exactly once (scoreboard count).

Source files
------------

// File: rtl/int_xing_pkg.sv
// rtl/int_xing_pkg.sv - shared constants and helpers for the interrupt async crossing
package int_xing_pkg;

    localparam int INT_XING_SINK_DEPTH = 3;

    // Counter width for a stretch of `hold` cycles; never narrower than one bit.
    function automatic int cnt_w(input int hold);
        return (hold <= 1) ? 1 : $clog2(hold);
    endfunction

    // Shortest HOLD that a sink with a (f_src/f_sink = ratio) clock is guaranteed to sample.
    function automatic int hold_min(input int ratio);
        return INT_XING_SINK_DEPTH * ratio + 3;
    endfunction

    function automatic bit params_ok(input int num_int, input int hold);
        return (num_int >= 1) && (hold >= 1) && (hold <= 255);
    endfunction

endpackage

// File: rtl/int_pulse_stretcher.sv
// rtl/int_pulse_stretcher.sv - one-bit rise-qualified pulse stretcher with retrigger
module int_pulse_stretcher
    import int_xing_pkg::*;
#(
    parameter int HOLD = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    localparam int             CW     = cnt_w(HOLD);
    localparam logic [CW-1:0]  RELOAD = CW'(HOLD - 1);

    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise;

    assign rise = d & ~prev_q;

    // A rise always reloads, so a retrigger on the expiring cycle leaves no low gap.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (rise) begin
            cnt_d = RELOAD;
            out_d = 1'b1;
        end else if (out_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            prev_q <= d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign q = out_q;

endmodule

// File: rtl/int_sync_async_crossing_source.sv
// rtl/int_sync_async_crossing_source.sv - source-side interrupt crossing: flop-driven, optional stretch
module int_sync_async_crossing_source
    import int_xing_pkg::*;
#(
    parameter int                 NUM_INT   = 1,
    parameter logic [NUM_INT-1:0] EDGE_MASK = '0,
    parameter int                 HOLD      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_INT-1:0] auto_in,
    output logic [NUM_INT-1:0] auto_out_sync
);

    if (!params_ok(NUM_INT, HOLD)) begin : g_bad_params
        $error("int_sync_async_crossing_source: illegal NUM_INT/HOLD");
    end

    logic [NUM_INT-1:0] r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= auto_in;
        end
    end

    // Every crossing bit is the Q of a flop: either a plain level flop or the stretcher's out flop.
    for (genvar i = 0; i < NUM_INT; i++) begin : g_line
        if (EDGE_MASK[i]) begin : g_edge
            int_pulse_stretcher #(
                .HOLD (HOLD)
            ) u_stretch (
                .clock (clock),
                .reset (reset),
                .d     (r_q[i]),
                .q     (auto_out_sync[i])
            );
        end else begin : g_level
            logic lvl_q;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    lvl_q <= 1'b0;
                end else begin
                    lvl_q <= r_q[i];
                end
            end
            assign auto_out_sync[i] = lvl_q;
        end
    end

endmodule
